systolic_mm_sequencer: RTL

//   Sequences one pass of the NxN output-stationary systolic matrix-multiply array in the PCPI

---
 rtl/systolic_mm_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/systolic_mm_sequencer.sv
// Control sequencer for one pass of the NxN output-stationary systolic array.
// It drives the skewed feed enables, the PE step and bias select, and the latch, busy and done lines.
module systolic_mm_sequencer #(
  parameter int N     = 3,
  parameter int IDX_W = ($clog2(N) < 1) ? 1 : $clog2(N),
  parameter int CNT_W = ($clog2(3*N) < 2) ? 2 : $clog2(3*N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               abort,
  input  logic               ack,
  output logic               pe_en,
  output logic               bias_sel,
  output logic [N-1:0]       feed_en,
  output logic [N*IDX_W-1:0] feed_idx,
  output logic               latch_en,
  output logic               busy,
  output logic               done,
  output logic               cfg_ok,
  output logic [CNT_W-1:0]   step
);

  localparam int STEPS = 3*N - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LATCH,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic               pe_en_q, pe_en_d;
  logic               bias_sel_q, bias_sel_d;
  logic [N-1:0]       feed_en_q, feed_en_d;
  logic [N*IDX_W-1:0] feed_idx_q, feed_idx_d;
  logic               latch_en_q, latch_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cfg_ok_q, cfg_ok_d;
  logic [CNT_W-1:0]   diff;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    unique case (state_q)
      IDLE: begin
        if (go && !abort) begin
          state_d = RUN;
          step_d  = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          step_d  = '0;
        end else if (step_q == LAST) begin
          state_d = LATCH;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      LATCH: begin
        if (abort) begin
          state_d = IDLE;
          step_d  = '0;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (abort || (ack && !go)) begin
          state_d = IDLE;
          step_d  = '0;
        end else if (go) begin
          state_d = RUN;
          step_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that they register alongside it.
  always_comb begin
    pe_en_d    = (state_d == RUN);
    bias_sel_d = (state_d == RUN) && (step_d == '0);
    latch_en_d = (state_d == LATCH);
    busy_d     = (state_d == RUN) || (state_d == LATCH);
    done_d     = (state_d == DONE);
    cfg_ok_d   = (state_d == IDLE) || (state_d == DONE);
    feed_en_d  = '0;
    feed_idx_d = '0;
    diff       = '0;
    if (state_d == RUN) begin
      for (int k = 0; k < N; k++) begin
        diff = step_d - CNT_W'(k);
        if ((step_d >= CNT_W'(k)) && (diff < CNT_W'(N))) begin
          feed_en_d[k] = 1'b1;
          feed_idx_d[k*IDX_W +: IDX_W] = diff[IDX_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= '0;
      pe_en_q    <= 1'b0;
      bias_sel_q <= 1'b0;
      feed_en_q  <= '0;
      feed_idx_q <= '0;
      latch_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_ok_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      pe_en_q    <= pe_en_d;
      bias_sel_q <= bias_sel_d;
      feed_en_q  <= feed_en_d;
      feed_idx_q <= feed_idx_d;
      latch_en_q <= latch_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_ok_q   <= cfg_ok_d;
    end
  end

  assign pe_en    = pe_en_q;
  assign bias_sel = bias_sel_q;
  assign feed_en  = feed_en_q;
  assign feed_idx = feed_idx_q;
  assign latch_en = latch_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cfg_ok   = cfg_ok_q;
  assign step     = step_q;

endmodule
